// File: rtl/board_switch_debounce_pkg.sv
// Shared sizing helpers for the board switch debouncer.
package board_switch_debounce_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_SWITCH_WIDTH = 10;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_COUNT = 4;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    // Run counter only has to reach STABLE_COUNT-1.
    function automatic int cnt_width(input int stable_count);
        return at_least_one(clog2(stable_count));
    endfunction

    function automatic int pre_width(input int tick_div);
        return at_least_one(clog2(tick_div));
    endfunction

    // Number of constant-zero bits above the switch field on the data buses.
    function automatic int pad_width(input int data_width, input int switch_width);
        return data_width - switch_width;
    endfunction

endpackage

// File: rtl/board_switch_debounce_cell.sv
// One debounced switch bit: consecutive-differing-sample counter plus accepted level.
module switch_debounce_cell
    import board_switch_debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic level,
    output logic accept_rise,
    output logic accept_fall
);

    localparam int CNT_WIDTH = cnt_width(STABLE_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;

    always_comb begin
        cnt_d       = cnt_q;
        level_d     = level_q;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        if (tick) begin
            if (sample == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d     = sample;
                cnt_d       = '0;
                accept_rise = sample;
                accept_fall = ~sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/board_switch_debounce.sv
// Switch debouncer top: sample prescaler, per-bit cells, sticky press/release flags.
module board_switch_debounce
    import board_switch_debounce_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int SWITCH_WIDTH = DEF_SWITCH_WIDTH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SWITCH_WIDTH-1:0] switch_in,
    output logic [DATA_WIDTH-1:0]   state,
    output logic [DATA_WIDTH-1:0]   press,
    output logic [DATA_WIDTH-1:0]   release_evt,
    output logic                    change,
    input  logic                    ack_we,
    input  logic [DATA_WIDTH-1:0]   ack_mask
);

    localparam int PRE_WIDTH = pre_width(TICK_DIV);
    localparam int PAD_WIDTH = pad_width(DATA_WIDTH, SWITCH_WIDTH);
    localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(TICK_DIV - 1);

    logic [PRE_WIDTH-1:0]    pre_q, pre_d;
    logic                    tick;
    logic [SWITCH_WIDTH-1:0] level;
    logic [SWITCH_WIDTH-1:0] accept_rise;
    logic [SWITCH_WIDTH-1:0] accept_fall;
    logic [SWITCH_WIDTH-1:0] clr_mask;
    logic [SWITCH_WIDTH-1:0] press_q, press_d;
    logic [SWITCH_WIDTH-1:0] release_q, release_d;
    logic                    change_q, change_d;

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    for (genvar i = 0; i < SWITCH_WIDTH; i++) begin : g_cell
        switch_debounce_cell #(
            .STABLE_COUNT(STABLE_COUNT)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .sample     (switch_in[i]),
            .level      (level[i]),
            .accept_rise(accept_rise[i]),
            .accept_fall(accept_fall[i])
        );
    end

    if (PAD_WIDTH > 0) begin : g_pad
        logic unused_ack_hi;
        assign unused_ack_hi = ^ack_mask[DATA_WIDTH-1:SWITCH_WIDTH];
    end

    // A new event in the same cycle as its clear survives: set is OR-ed in last.
    always_comb begin
        clr_mask  = ack_we ? ack_mask[SWITCH_WIDTH-1:0] : '0;
        press_d   = (press_q & ~clr_mask) | accept_rise;
        release_d = (release_q & ~clr_mask) | accept_fall;
        change_d  = |(accept_rise | accept_fall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            change_q  <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            press_q   <= press_d;
            release_q <= release_d;
            change_q  <= change_d;
        end
    end

    always_comb begin
        state       = '0;
        press       = '0;
        release_evt = '0;
        state[SWITCH_WIDTH-1:0]       = level;
        press[SWITCH_WIDTH-1:0]       = press_q;
        release_evt[SWITCH_WIDTH-1:0] = release_q;
        change                        = change_q;
    end

endmodule

// File: tb/tb_board_switch_debounce.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-count model.
module tb_board_switch_debounce;

    localparam int DW  = 16;
    localparam int SW  = 10;
    localparam int TD  = 4;
    localparam int SC  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] switch_in;
    logic [DW-1:0] state, press, release_evt;
    logic          change;
    logic          ack_we;
    logic [DW-1:0] ack_mask;

    int n_tests = 0;
    int n_fail  = 0;

    board_switch_debounce #(
        .DATA_WIDTH  (DW),
        .SWITCH_WIDTH(SW),
        .TICK_DIV    (TD),
        .STABLE_COUNT(SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .switch_in  (switch_in),
        .state      (state),
        .press      (press),
        .release_evt(release_evt),
        .change     (change),
        .ack_we     (ack_we),
        .ack_mask   (ack_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: ticks from a cycle count since reset, per-bit run lengths.
    int            m_cyc;
    int            m_run [SW];
    logic [SW-1:0] m_state, m_press, m_rel;
    logic          m_change;
    int            change_seen;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        logic [SW-1:0] clr;
        logic          acc;
        if (reset) begin
            m_cyc = 0; m_state = '0; m_press = '0; m_rel = '0; m_change = 1'b0;
            for (int i = 0; i < SW; i++) m_run[i] = 0;
        end else begin
            clr = ack_we ? ack_mask[SW-1:0] : '0;
            m_press = m_press & ~clr;
            m_rel   = m_rel & ~clr;
            acc = 1'b0;
            if ((m_cyc % TD) == TD - 1) begin
                for (int i = 0; i < SW; i++) begin
                    if (switch_in[i] == m_state[i]) m_run[i] = 0;
                    else begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == SC) begin
                            m_state[i] = switch_in[i];
                            if (switch_in[i]) m_press[i] = 1'b1;
                            else              m_rel[i]   = 1'b1;
                            m_run[i] = 0;
                            acc = 1'b1;
                        end
                    end
                end
            end
            m_change = acc;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state",   state,       {6'b0, m_state});
            check("press",   press,       {6'b0, m_press});
            check("release", release_evt, {6'b0, m_rel});
            check("change",  {15'b0, change}, {15'b0, m_change});
            if (change) change_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    int c0;
    bit hit;

    initial begin
        reset = 1'b1; switch_in = '0; ack_we = 1'b0; ack_mask = '0;
        change_seen = 0;
        step(2);
        chk_en = 1'b1;
        reset = 1'b0;

        // Idle after reset
        step(40);
        check("idle_state", state, 16'h0000);
        check("idle_press", press, 16'h0000);
        check("idle_change_cnt", 16'(change_seen), 16'd0);

        // Glitch rejection on bit 3 (2 ticks high, 1 low, 2 high)
        switch_in = 10'h008; step(8);
        switch_in = 10'h000; step(4);
        switch_in = 10'h008; step(8);
        switch_in = 10'h000; step(8);
        check("glitch_state", state, 16'h0000);
        check("glitch_press", press, 16'h0000);

        // Clean press of bit 0, tick-aligned from reset: 3rd tick is cycle 11
        do_reset(2);
        switch_in = 10'h001;
        c0 = change_seen;
        step(11);
        check("press_early", state, 16'h0000);
        step(1);
        check("press_state", state, 16'h0001);
        check("press_flag",  press, 16'h0001);
        step(8);
        check("press_change_once", 16'(change_seen - c0), 16'd1);

        // Release then clear
        switch_in = 10'h000;
        step(13);
        check("rel_flag", release_evt, 16'h0001);
        ack_we = 1'b1; ack_mask = 16'hFFFF;
        step(1);
        ack_we = 1'b0; ack_mask = '0;
        check("clr_press", press, 16'h0000);
        check("clr_rel",   release_evt, 16'h0000);
        check("clr_state", state, 16'h0000);

        // Set and clear of bit 9 in the same cycle
        switch_in = 10'h200;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if ((m_cyc % TD) == TD - 1 && m_run[9] == SC - 1 && m_state[9] != switch_in[9]) begin
                ack_we = 1'b1; ack_mask = 16'h0200;
                step(1);
                ack_we = 1'b0; ack_mask = '0;
                hit = 1'b1;
                check("setwins_press9", {15'b0, press[9]}, 16'd1);
            end else step(1);
        end
        check("setwins_reached", {15'b0, hit}, 16'd1);
        ack_we = 1'b1; ack_mask = 16'h0200;
        step(1);
        ack_we = 1'b0; ack_mask = '0;
        check("setwins_cleared", {15'b0, press[9]}, 16'd0);

        // Reset mid-debounce
        do_reset(2);
        switch_in = 10'h3FF;
        step(8);
        do_reset(2);
        step(11);
        check("mid_state_hold", state, 16'h0000);
        step(1);
        check("mid_state", state, 16'h03FF);
        check("mid_press", press, 16'h03FF);
        check("mid_upper", release_evt & 16'hFC00, 16'h0000);

        // Random traffic: sparse switch toggles and acks with upper mask bits noise
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) switch_in = switch_in ^ SW'($urandom);
            ack_we   = ($urandom_range(0, 9) == 0);
            ack_mask = DW'($urandom);
            step(1);
        end
        ack_we = 1'b0;
        step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_switch_debounce.md
# board_switch_debounce

Per-bit debouncer and event latch for the board slide switches and push buttons. Sits directly downstream of the switch synchronizer: it consumes the already-synchronized switch vector and samples it on a slow prescaled tick. It requires each bit to hold a new level for a configurable number of consecutive samples before accepting it. It publishes the debounced level plus sticky press/release event flags, which the CPU reads and clears with write-1-to-clear.

## Interface
Parameters:
- DATA_WIDTH, 16: width of the CPU-facing data buses; upper bits above SWITCH_WIDTH read as 0.
- SWITCH_WIDTH, 10: number of switch bits debounced (must be at most DATA_WIDTH).
- TICK_DIV, 50000: clk cycles per sample tick (at least 2).
- STABLE_COUNT, 4: consecutive differing samples needed to accept a new level (at least 1).

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: synchronous, active-high reset.
- switch_in, input, SWITCH_WIDTH: synchronized switch levels (already in the clk domain).
- state, output, DATA_WIDTH: debounced levels, zero-extended.
- press, output, DATA_WIDTH: sticky flags for accepted 0→1 transitions, zero-extended.
- release, output, DATA_WIDTH: sticky flags for accepted 1→0 transitions, zero-extended.
- change, output, 1: one-cycle pulse when any bit of state changes.
- ack_we, input, 1: clear strobe for press and release.
- ack_mask, input, DATA_WIDTH: write-1-to-clear mask, applied to press and release when ack_we=1; bits at or above SWITCH_WIDTH are ignored.

## Operation
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. The internal tick is high for exactly the one cycle in which the counter equals TICK_DIV-1.
- Per bit i, evaluated only on tick cycles:
  - switch_in[i] == state[i]: cnt[i] ← 0.
  - switch_in[i] != state[i] and cnt[i] < STABLE_COUNT-1: cnt[i] ← cnt[i]+1.
  - switch_in[i] != state[i] and cnt[i] == STABLE_COUNT-1: state[i] ← switch_in[i], cnt[i] ← 0, and press[i] ← 1 (new level 1) or release[i] ← 1 (new level 0).
- A single agreeing sample anywhere in the run resets the count, so glitches shorter than STABLE_COUNT ticks are rejected entirely.
- Counter width is clog2(STABLE_COUNT), with a minimum of 1 bit. The counter never exceeds STABLE_COUNT-1.
- With STABLE_COUNT=1, a bit is accepted on the first differing tick.
- change is asserted in the cycle after a tick in which at least one bit was accepted.
- Clear behaviour:
  - On ack_we=1, every press/release bit with its ack_mask bit set goes to 0.
  - If a set and a clear hit the same bit in the same cycle, set wins (the event is not lost).
  - Clearing has no effect on state or cnt.
- press and release are independent. Both may be set for the same bit if the switch toggles twice before the CPU acknowledges.
- Reset:
  - state, press, release, change, all cnt, and the prescaler go to 0.
  - A switch held high through reset is accepted STABLE_COUNT ticks later and logs a press event. This is intended behaviour.
- Reset mid-debounce discards partial counts; no event is generated for an interrupted run.

## Timing
- All outputs are registered. None is combinational from switch_in, ack_we or ack_mask.
- After reset deasserts, the first tick occurs on the TICK_DIV-th cycle.
- Acceptance latency, from the first differing sample to the state update: (STABLE_COUNT-1)·TICK_DIV cycles plus one cycle. The state/press/release update is visible the cycle after the accepting tick cycle.
- change is high for exactly one cycle, aligned with the cycle in which the new state first appears.
- Clear latency: press/release bits read 0 in the cycle after the ack_we cycle.
- Changes on switch_in between ticks are ignored. Only the value present in the tick cycle is sampled.

## Structure
- Shared package/header holds:
  - the clog2 helper;
  - the derived localparams CNT_WIDTH and PRE_WIDTH (prescaler width, clog2(TICK_DIV));
  - the zero-extension width rule.
- One sub-module, switch_debounce_cell. It holds the per-bit counter and state, and produces accept_rise/accept_fall pulses.
  - It is instantiated SWITCH_WIDTH times in a generate loop.
  - The prescaler and the press/release/change registers stay in the top level.

## Test plan
All scenarios run with TICK_DIV=4, STABLE_COUNT=3, SWITCH_WIDTH=10, DATA_WIDTH=16.
- Reset, switches=0: after 40 cycles, state=press=release=0x0000 and change was never asserted; the tick period measures 4 cycles.
- Clean press of bit 0: switch_in=0x001 held. state becomes 0x0001 on the cycle after the 3rd sampled tick, press=0x0001, and change pulses exactly once.
- Glitch rejection on bit 3: high for 2 ticks, low for 1, high for 2, then low. state and press stay 0x0000 throughout.
- Release and clear: from state=0x0001 and press=0x0001, drop the bit. release=0x0001 appears. Then ack_we=1 with ack_mask=0xFFFF gives press=release=0x0000 next cycle, while state stays 0x0000.
- Simultaneous set and clear: ack_we=1 with ack_mask=0x0200 in the exact cycle bit 9 is accepted high. Next cycle press[9]=1; a later ack clears it.
- Reset mid-debounce with switch_in=0x3FF:
  - Assert reset after 2 ticks. After release of reset, state stays 0x0000 until 3 fresh ticks have been sampled.
  - Then state=0x03FF and press=0x03FF; bits 15:10 remain 0 on all outputs.
